// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, widths, FSM states.
// Used by md_calc and md_unit.
package md_pkg;

    localparam int XLEN = 32;
    localparam int DLEN = 2 * XLEN;
    localparam int OPW  = 3;

    localparam logic [OPW-1:0] MD_MULT  = 3'd0;
    localparam logic [OPW-1:0] MD_MULTU = 3'd1;
    localparam logic [OPW-1:0] MD_DIV   = 3'd2;
    localparam logic [OPW-1:0] MD_DIVU  = 3'd3;
    localparam logic [OPW-1:0] MD_MTHI  = 3'd4;
    localparam logic [OPW-1:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops 0..3 are the multi-cycle arithmetic ops; bit 1 separates divide from multiply.
    function automatic logic md_is_arith(input logic [OPW-1:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_div(input logic [OPW-1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [OPW-1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Result is {hi, lo}; div_zero_o flags a divide with a zero divisor.
module md_calc
    import md_pkg::*;
(
    input  logic [OPW-1:0]  op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [DLEN-1:0] res_o,
    output logic            div_zero_o
);

    logic            sgn;
    logic [DLEN-1:0] a_ext;
    logic [DLEN-1:0] b_ext;
    logic [DLEN-1:0] prod;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] b_safe;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    assign sgn = md_is_signed(op_i);

    // The low 64 bits of a 64x64 product of extended operands cover both signednesses.
    assign a_ext = {{XLEN{sgn & a_i[XLEN-1]}}, a_i};
    assign b_ext = {{XLEN{sgn & b_i[XLEN-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude,
    // which makes the signed overflow case fall out as quotient 0x80000000, remainder 0.
    assign a_neg  = sgn & a_i[XLEN-1];
    assign b_neg  = sgn & b_i[XLEN-1];
    assign a_mag  = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_mag  = b_neg ? (~b_i + 32'd1) : b_i;
    assign b_safe = (b_i == '0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign res_o      = md_is_div(op_i) ? {rem, quo} : prod;
    assign div_zero_o = md_is_div(op_i) & (b_i == '0);

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO; arith ops busy for MULT_CYCLES/DIV_CYCLES, MTHI/MTLO in one cycle.
// Backpressure: busy and combinational stall_req; starts while busy are ignored. MD_UNIT_FLUSH_EN adds flush abort.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic            clk,
    input  logic            reset,
`ifdef MD_UNIT_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            start,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] sl_q;
    logic            dz_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic [DLEN-1:0] res_d;
    logic            dz_d;
    logic            flush_w;

`ifdef MD_UNIT_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    md_calc u_calc (
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .res_o      (res_d),
        .div_zero_o (dz_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            sl_q    <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !flush_w) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                state_q <= RUN;
                                cnt_q   <= md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                                sh_q    <= res_d[DLEN-1:XLEN];
                                sl_q    <= res_d[XLEN-1:0];
                                dz_q    <= dz_d;
                            end
                            MD_MTHI: hi_q <= a;
                            MD_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Any start seen here is dropped; only flush or completion leave RUN.
                    if (flush_w) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        if (!dz_q) begin
                            hi_q <= sh_q;
                            lo_q <= sl_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign stall_req = busy | (start & md_is_arith(op));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the pipelined MIPS core; sits beside the ALU in the EX stage.
- Responder side of a start/busy handshake: EX issues the operation and the hazard logic stalls on busy.
- Holds the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU with fixed multi-cycle latency, and MTHI/MTLO with single-cycle latency.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request strobe from EX.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (no-op).
- a  input  32  rs operand.
- b  input  32  rt operand.
- busy  output  1  operation in flight.
- stall_req  output  1  combinational: busy | (start & op<=3); drives hazard logic for MFHI/MFLO/md ops in D.
- hi  output  32  HI register.
- lo  output  32  LO register.
- flush  input  1  present only with MD_UNIT_FLUSH_EN.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous, active-high and sampled only on the rising edge. While high: busy=0, hi=0, lo=0, counter=0, shadow registers=0.
- State machine: IDLE and RUN.
  - IDLE: start & op in {0..3} sampled at edge k -> RUN. Load counter with MULT_CYCLES or DIV_CYCLES. Compute the 64-bit result into shadow {sh,sl}.
- Busy timing:
  - busy=1 during cycles k+1 .. k+N, where N is the selected latency.
  - On the edge ending cycle k+N: hi<=sh, lo<=sl, busy<=0, return to IDLE.
  - New hi/lo are visible in cycle k+N+1, the same cycle busy reads 0.
- Arithmetic:
  - MULT: signed 32x32 -> 64; {hi,lo} = product.
  - MULTU: unsigned 32x32 -> 64; {hi,lo} = product.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (b==0, DIV/DIVU): runs the full DIV_CYCLES, then hi/lo are left unchanged (no commit).
- Signed overflow: DIV with 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTHI/MTLO: in IDLE, start & op=4/5 writes hi (or lo) <= a at edge k. busy stays 0.
- start while busy: ignored entirely (the pipeline guarantees it does not happen; the design must still be safe). This includes MTHI/MTLO; the in-flight result is unaffected.
- Reserved op with start: no state change.
- Operands are sampled only at the start edge; later changes to a/b during RUN have no effect.
- Reset mid-operation: abort, outputs return to reset values, no commit.

Optional Feature:
- Macro MD_UNIT_FLUSH_EN.
- Defined:
  - Adds the flush input, used for exception/eret in the later pipeline.
  - flush=1 at an edge during RUN aborts the operation: busy<=0, hi/lo unchanged, IDLE.
  - flush=1 together with start in IDLE suppresses the start (no state change, including MTHI/MTLO).
  - flush has lower priority than reset.
- Undefined: no flush port; an operation always runs to completion.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO (3-bit).
  - localparam widths.
  - state encoding IDLE/RUN.
- Natural sub-module md_calc: combinational 64-bit result generator (mult/div signed/unsigned, div-by-zero flag).
- md_unit keeps the counter, state, shadow and HI/LO registers.

Test Plan:
- Signed multiply: reset, then start op=MULT a=0xFFFFFFFD(-3) b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall_req high in the start cycle.
- Unsigned multiply: MULTU a=0xFFFFFFFF b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7 b=2 -> lo=3, hi=1.
- Divide by zero: MTHI a=0x12345678; next cycle MTLO a=0x9ABCDEF0 (each visible the cycle after start, busy=0). Then DIV b=0 -> after 10 busy cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- Ignored start and mid-op reset: MULT 3*4, then start MTLO a=0xAAAA at busy cycle 2 -> ignored; lo=12 at completion. New MULT, reset asserted at busy cycle 3 -> busy=0, hi=lo=0, no later commit.
- Flush (with MD_UNIT_FLUSH_EN): DIVU 100/7 with flush at busy cycle 4 -> busy drops the next cycle, hi/lo unchanged. Rerun without flush -> lo=14, hi=2.
